// File: rtl/pc_sequencer.sv
// Fetch-stage program counter sequencer: start, step, stall, LUT branch, halt.
// Branch targets come from an external LUT in the same cycle.
module pc_sequencer #(
  parameter int D  = 10,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          branch_rel,
  input  logic [3:0]    branch_idx,
  input  logic [D-1:0]  lut_target,
  input  logic          halt_req,
  output logic [3:0]    lut_addr,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_valid,
  output logic          done,
  output logic [CW-1:0] cycle_cnt,
  output logic [CW-1:0] branch_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [CW-1:0] CMAX = '1;

  logic [1:0]   state;
  logic         do_halt;
  logic         do_abs;
  logic         do_rel;
  logic         do_inc;
  logic         take_br;
  logic [D-1:0] next_pc;

  assign lut_addr    = branch_idx;
  assign fetch_valid = (state == RUN) && !stall;
  assign done        = (state == HALT);

  // Mutually exclusive decode of halt > branch > increment
  assign do_halt = halt_req;
  assign do_abs  = !halt_req && branch_en && !branch_rel;
  assign do_rel  = !halt_req && branch_en && branch_rel;
  assign do_inc  = !halt_req && !branch_en;
  assign take_br = do_abs || do_rel;

  always_comb begin
    next_pc = prog_ctr;
    unique case (1'b1)
      do_halt: next_pc = prog_ctr;
      do_abs:  next_pc = lut_target;
      do_rel:  next_pc = prog_ctr + lut_target;
      do_inc:  next_pc = prog_ctr + D'(1);
      default: next_pc = prog_ctr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prog_ctr   <= '0;
      cycle_cnt  <= '0;
      branch_cnt <= '0;
    end else begin
      unique case (state)
        IDLE, HALT: begin
          if (start) begin
            state      <= RUN;
            prog_ctr   <= '0;
            cycle_cnt  <= '0;
            branch_cnt <= '0;
          end
        end
        RUN: begin
          if (cycle_cnt != CMAX)
            cycle_cnt <= cycle_cnt + CW'(1);
          if (!stall) begin
            prog_ctr <= next_pc;
            if (take_br && branch_cnt != CMAX)
              branch_cnt <= branch_cnt + CW'(1);
            if (do_halt)
              state <= HALT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed steps push expected outputs,
// a monitor pops and compares after each rising edge.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stall;
  logic       branch_en, branch_rel, halt_req;
  logic [3:0] branch_idx;
  logic [9:0] lut_target;
  logic [3:0] lut_addr;
  logic [9:0] prog_ctr;
  logic       fetch_valid, done;
  logic [15:0] cycle_cnt, branch_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [9:0]  pc;
    logic [15:0] cyc;
    logic [15:0] br;
    logic        fv;
    logic        dn;
    logic [3:0]  la;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pc_sequencer #(.D(10), .CW(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stall(stall),
    .branch_en(branch_en),
    .branch_rel(branch_rel),
    .branch_idx(branch_idx),
    .lut_target(lut_target),
    .halt_req(halt_req),
    .lut_addr(lut_addr),
    .prog_ctr(prog_ctr),
    .fetch_valid(fetch_valid),
    .done(done),
    .cycle_cnt(cycle_cnt),
    .branch_cnt(branch_cnt)
  );

  // Monitor: one expected entry per clock edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (prog_ctr !== e.pc || cycle_cnt !== e.cyc ||
          branch_cnt !== e.br || fetch_valid !== e.fv ||
          done !== e.dn || lut_addr !== e.la) begin
        errors++;
        $display("FAIL %s: got pc=%0d cyc=%0d br=%0d fv=%0b dn=%0b la=%0d exp pc=%0d cyc=%0d br=%0d fv=%0b dn=%0b la=%0d",
                 e.name, prog_ctr, cycle_cnt, branch_cnt, fetch_valid,
                 done, lut_addr, e.pc, e.cyc, e.br, e.fv, e.dn, e.la);
      end
    end
  end

  task automatic step(
    input string      nm,
    input logic       rst, st, stl, be, brl, hr,
    input logic [3:0] idx,
    input logic [9:0] lt,
    input logic [9:0] epc,
    input int         ecyc, ebr,
    input logic       efv, edn
  );
    exp_t e;
    @(negedge clk);
    reset      = rst;
    start      = st;
    stall      = stl;
    branch_en  = be;
    branch_rel = brl;
    halt_req   = hr;
    branch_idx = idx;
    lut_target = lt;
    e.name = nm;
    e.pc   = epc;
    e.cyc  = 16'(ecyc);
    e.br   = 16'(ebr);
    e.fv   = efv;
    e.dn   = edn;
    e.la   = idx;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    branch_en = 1'b0; branch_rel = 1'b0; halt_req = 1'b0;
    branch_idx = 4'd0; lut_target = 10'd0;

    //       name       rst st stl be rel hr idx lut      pc  cyc br fv dn
    step("reset0",      1, 0, 0, 0, 0, 0, 0, 10'd0,     0,  0, 0, 0, 0);
    step("reset1",      1, 1, 0, 0, 0, 0, 3, 10'd0,     0,  0, 0, 0, 0);
    step("idle_ign",    0, 0, 0, 1, 0, 1, 6, 10'd50,    0,  0, 0, 0, 0);
    step("start",       0, 1, 0, 0, 0, 0, 0, 10'd0,     0,  0, 0, 1, 0);
    for (int i = 1; i <= 5; i++)
      step("free",      0, 0, 0, 0, 0, 0, 0, 10'd0,  10'(i), i, 0, 1, 0);
    step("rel_m1",      0, 0, 0, 1, 1, 0, 7, 10'h3FF,   4,  6, 1, 1, 0);
    step("abs_idx1",    0, 0, 0, 1, 0, 0, 1, 10'd9,     9,  7, 2, 1, 0);
    step("abs_idx2",    0, 0, 0, 1, 0, 0, 2, 10'd17,   17,  8, 3, 1, 0);
    step("abs_to4",     0, 0, 0, 1, 0, 0, 3, 10'd4,     4,  9, 4, 1, 0);
    step("rel_m1_b",    0, 0, 0, 1, 1, 0, 4, 10'h3FF,   3, 10, 5, 1, 0);
    step("rel_p20",     0, 0, 0, 1, 1, 0, 8, 10'd20,   23, 11, 6, 1, 0);
    step("abs_1023",    0, 0, 0, 1, 0, 0, 5, 10'd1023, 1023, 12, 7, 1, 0);
    step("inc_wrap",    0, 1, 0, 0, 0, 0, 0, 10'd0,     0, 13, 7, 1, 0);
    step("free_1",      0, 0, 0, 0, 0, 0, 0, 10'd0,     1, 14, 7, 1, 0);
    step("free_2",      0, 0, 0, 0, 0, 0, 0, 10'd0,     2, 15, 7, 1, 0);
    step("rel_m5",      0, 0, 0, 1, 1, 0, 9, 10'h3FB, 1021, 16, 8, 1, 0);
    step("rel_p5_wrap", 0, 0, 0, 1, 1, 0, 9, 10'd5,     2, 17, 9, 1, 0);
    step("stall1",      0, 0, 1, 1, 0, 1, 2, 10'd17,    2, 18, 9, 0, 0);
    step("stall2",      0, 0, 1, 1, 0, 1, 2, 10'd17,    2, 19, 9, 0, 0);
    step("stall3",      0, 0, 1, 1, 0, 1, 2, 10'd17,    2, 20, 9, 0, 0);
    step("halt",        0, 0, 0, 1, 0, 1, 2, 10'd17,    2, 21, 9, 0, 1);
    step("halt_hold",   0, 0, 0, 1, 0, 0, 2, 10'd17,    2, 21, 9, 0, 1);
    step("restart",     0, 1, 0, 0, 0, 0, 0, 10'd0,     0,  0, 0, 1, 0);
    for (int i = 1; i <= 7; i++)
      step("run2",      0, 0, 0, 0, 0, 0, 0, 10'd0,  10'(i), i, 0, 1, 0);
    step("start_run",   0, 1, 0, 0, 0, 0, 0, 10'd0,     8,  8, 0, 1, 0);
    step("rst_start",   1, 1, 0, 1, 0, 0, 1, 10'd9,     0,  0, 0, 0, 0);
    step("idle_after",  0, 0, 0, 1, 0, 0, 1, 10'd9,     0,  0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
